// File: rtl/pll_cfg_sequencer.sv
// PLL configuration sequencer: accepts read / write / read-modify-write
// commands and runs them as strobe/ack bus cycles on one of N_PLL
// configuration ports. Each STB phase is bounded by a timeout counter.
module pll_cfg_sequencer #(
  parameter int N_PLL   = 2,
  parameter int DW      = 8,
  parameter int AW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                PLLCLK,
  input  logic                PLLRSTN,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_WE,
  input  logic [2:0]          CMD_SEL,
  input  logic [AW-1:0]       CMD_ADDR,
  input  logic [DW-1:0]       CMD_DATA,
  input  logic [DW-1:0]       CMD_MASK,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [DW-1:0]       RSP_DATA,
  output logic                RSP_ERR,
  output logic                BUSY,
  output logic [N_PLL-1:0]    PLLSTB,
  output logic                PLLWE,
  output logic [AW-1:0]       PLLADDR,
  output logic [DW-1:0]       PLLDATI,
  input  logic [N_PLL*DW-1:0] PLLDATO,
  input  logic [N_PLL-1:0]    PLLACK
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP, S_WR, S_RESP} state_t;

  // Counter value on the last allowed STB cycle: STB stays high TIMEOUT cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  NP       = 4'(N_PLL);

  state_t        state, state_nxt;
  logic [2:0]    sel_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, mask_q, rsp_data_q;
  logic          rsp_err_q, rmw_q;
  logic [15:0]   cnt;

  logic          accept, bad_sel, full_mask, ack_sel, tmo;
  logic [DW-1:0] dato_sel;

  assign accept    = CMD_VALID && (state == S_IDLE);
  assign bad_sel   = {1'b0, CMD_SEL} >= NP;
  assign full_mask = &CMD_MASK;
  assign tmo       = (cnt == TMO_LAST);

  // Pick ack and read data of the latched port; other ports are ignored.
  always_comb begin
    ack_sel  = 1'b0;
    dato_sel = '0;
    for (int k = 0; k < N_PLL; k++) begin
      if (sel_q == 3'(k)) begin
        ack_sel  = PLLACK[k];
        dato_sel = PLLDATO[k*DW +: DW];
      end
    end
  end

  // State register; reset drops the strobe immediately since it decodes state.
  always_ff @(posedge PLLCLK or negedge PLLRSTN) begin
    if (!PLLRSTN) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; ack takes priority over timeout on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (CMD_VALID) begin
        if (bad_sel)                   state_nxt = S_RESP;
        else if (CMD_WE && full_mask)  state_nxt = S_WR;
        else                           state_nxt = S_RD;
      end
      S_RD: begin
        if (ack_sel)  state_nxt = rmw_q ? S_GAP : S_RESP;
        else if (tmo) state_nxt = S_RESP;
      end
      S_GAP:  state_nxt = S_WR;
      S_WR:   if (ack_sel || tmo) state_nxt = S_RESP;
      S_RESP: if (RSP_READY) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: handshakes and one-hot strobe for the latched port.
  always_comb begin
    CMD_READY = (state == S_IDLE);
    BUSY      = (state != S_IDLE);
    PLLWE     = (state == S_WR);
    RSP_VALID = (state == S_RESP);
    PLLSTB    = '0;
    if (state == S_RD || state == S_WR)
      for (int k = 0; k < N_PLL; k++) PLLSTB[k] = (sel_q == 3'(k));
  end

  // Command latch, RMW merge, timeout counter and response registers.
  always_ff @(posedge PLLCLK or negedge PLLRSTN) begin
    if (!PLLRSTN) begin
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      rmw_q      <= 1'b0;
      cnt        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          sel_q   <= CMD_SEL;
          addr_q  <= CMD_ADDR;
          wdata_q <= CMD_DATA;
          mask_q  <= CMD_MASK;
          rmw_q   <= CMD_WE;   // only reaches RD with WE=1 when mask is partial
          cnt     <= '0;
          if (bad_sel) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        S_RD: begin
          cnt <= cnt + 16'd1;
          if (ack_sel) begin
            if (rmw_q) wdata_q <= (dato_sel & ~mask_q) | (wdata_q & mask_q);
            else begin
              rsp_data_q <= dato_sel;
              rsp_err_q  <= 1'b0;
            end
          end else if (tmo) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        S_GAP: cnt <= '0;
        S_WR: begin
          cnt <= cnt + 16'd1;
          if (ack_sel) begin
            rsp_data_q <= wdata_q;
            rsp_err_q  <= 1'b0;
          end else if (tmo) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PLLADDR  = addr_q;
  assign PLLDATI  = wdata_q;
  assign RSP_DATA = rsp_data_q;
  assign RSP_ERR  = rsp_err_q;

endmodule

// File: doc/pll_cfg_sequencer.md
PLL_CFG_SEQUENCER -- requirements
Module: pll_cfg_sequencer

Interface
REQ-001 The block SHALL have parameter N_PLL, default 2, giving the number of PLL configuration ports served (1..8).
REQ-002 The block SHALL have parameter DW, default 8, giving the configuration data width.
REQ-003 The block SHALL have parameter AW, default 5, giving the configuration address width.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of STB-high cycles allowed without ACK (1..65535).
REQ-005 The block SHALL use one clock and an asynchronous active-low reset, with these ports:
- PLLCLK  in  1  clock
- PLLRSTN  in  1  async active-low reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted when high with CMD_VALID
- CMD_WE  in  1  1=write, 0=read
- CMD_SEL  in  3  target PLL index
- CMD_ADDR  in  AW  register address
- CMD_DATA  in  DW  write data
- CMD_MASK  in  DW  write bit-enable; all-ones=plain write
- RSP_VALID  out  1  response available
- RSP_READY  in  1  response consumed
- RSP_DATA  out  DW  response data
- RSP_ERR  out  1  timeout or bad select
- BUSY  out  1  high in any state except IDLE
- PLLSTB  out  N_PLL  per-port strobe
- PLLWE  out  1  bus write enable
- PLLADDR  out  AW  bus address
- PLLDATI  out  DW  bus write data to PLL
- PLLDATO  in  N_PLL*DW  per-port read data, port k at bits [k*DW +: DW]
- PLLACK  in  N_PLL  per-port acknowledge

Function
REQ-006 The FSM SHALL have the states IDLE, RD, GAP, WR, RESP.
REQ-007 CMD_READY SHALL be 1 only in IDLE; a command SHALL be accepted on a rising edge where CMD_VALID=CMD_READY=1, and all CMD_* fields SHALL be latched on that edge.
REQ-008 On acceptance, the next state SHALL be:
- RESP with RSP_ERR=1 and RSP_DATA=0 if CMD_SEL>=N_PLL;
- WR if CMD_WE=1 and CMD_MASK is all-ones;
- RD otherwise (a read, or a read-modify-write when CMD_WE=1 and the mask is partial).
REQ-009 In RD and WR, only PLLSTB[sel] SHALL be 1.
- PLLWE SHALL be 1 in WR and 0 in RD.
- PLLADDR and PLLDATI SHALL hold stable for the whole cycle.
- All PLLSTB bits SHALL be 0 in every other state.
REQ-010 A bus cycle SHALL end on the first edge where PLLACK[sel]=1 while PLLSTB[sel]=1, and PLLSTB SHALL be 0 in the following cycle.
REQ-011 PLLACK bits for unselected ports, and any PLLACK bit while PLLSTB is 0, SHALL be ignored.
REQ-012 On ACK in RD, PLLDATO[sel] SHALL be captured.
- Plain read: next state RESP.
- Read-modify-write: next state GAP, with write data = (captured & ~MASK) | (DATA & MASK).
REQ-013 GAP SHALL last exactly one cycle with all strobes low, then go to WR.
REQ-014 On ACK in WR, the next state SHALL be RESP, with RSP_DATA equal to the value written.
REQ-015 A 16-bit counter SHALL clear on entry to RD or WR and increment each STB-high cycle.
- If the counter reaches TIMEOUT without ACK, the strobe SHALL drop and the next state SHALL be RESP with RSP_ERR=1 and RSP_DATA=0.
- A timeout in the read phase of a read-modify-write SHALL abort the write; no WR cycle is issued.
- If ACK arrives on the same edge the counter reaches TIMEOUT, the ACK SHALL win and RSP_ERR SHALL be 0.
REQ-016 In RESP, RSP_VALID SHALL be 1, with RSP_DATA and RSP_ERR held stable until the edge where RSP_READY=1; the next state SHALL then be IDLE.
REQ-017 Latency: for a read acked in the first STB cycle, acceptance at edge 0 SHALL give STB high in cycle 1 and RSP_VALID high in cycle 2.
REQ-018 No new command SHALL be accepted in the cycle RESP exits, because CMD_READY rises only in IDLE.

Reset
REQ-019 PLLRSTN=0 SHALL asynchronously force state IDLE and the outputs to:
- PLLSTB=0, PLLWE=0, PLLADDR=0, PLLDATI=0;
- RSP_VALID=0, RSP_DATA=0, RSP_ERR=0;
- BUSY=0, counter=0.
REQ-020 Reset asserted mid-transaction SHALL drop PLLSTB immediately, without waiting for a clock edge, and SHALL discard the pending command with no response issued.
REQ-021 After reset deassertion, CMD_READY SHALL be 1 from the first clock edge.

Verification
REQ-022 Read: SEL=1, ADDR=0x03, PLLDATO[1]=0x5A, ACK after 2 STB cycles -> PLLSTB=2'b10 with WE=0 for 2 cycles, then RSP_DATA=0x5A, RSP_ERR=0.
REQ-023 Read-modify-write: MASK=0x0F, DATA=0x06, read returns 0xA3 -> one GAP cycle, then WR with PLLDATI=0xA6 and RSP_DATA=0xA6.
REQ-024 Timeout: TIMEOUT=4, no ACK -> STB high exactly 4 cycles, then RSP_ERR=1, RSP_DATA=0; in the read-modify-write case, no WR strobe occurs.
REQ-025 Bad select: N_PLL=2, SEL=3 -> no strobe, RSP_VALID one cycle after acceptance with RSP_ERR=1.
REQ-026 Backpressure and reset: hold RSP_READY=0 for 5 cycles -> RSP outputs stable and CMD_READY=0; PLLRSTN pulsed during STB -> PLLSTB=0 asynchronously and no RSP_VALID.
REQ-027 Stray ACK: PLLACK[0]=1 while SEL=1 is strobed -> ignored, and the transaction completes only on PLLACK[1].
